mem_bus_controller: RTL and testbench



---
 rtl/mem_bus_pkg.sv | 18 +
 rtl/bus_wait_timer.sv | 34 +++
 rtl/mem_bus_controller.sv | 141 ++++++++++++++
 tb/tb_mem_bus_controller.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-bus controller.
// Optional feature macro used by the controller: MEM_BUS_POSTED_WRITE_EN.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE,
        FAULT
    } bus_state_t;

    // Width of the ACCESS-cycle wait counter.
    localparam int unsigned CNT_WIDTH = 8;

    // Read data returned to the core on a faulted read (sliced to DATA_WIDTH).
    localparam logic [63:0] FAULT_DATA = '1;

endpackage

// File: rtl/bus_wait_timer.sv
// Clearable ACCESS-cycle counter with minimum-wait and timeout flags.
module bus_wait_timer
    import mem_bus_pkg::*;
#(
    parameter int unsigned MIN_WAIT = 0,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic clk,
    input  logic clear,
    output logic min_met,
    output logic expired
);

    localparam logic [CNT_WIDTH-1:0] MIN_CNT = CNT_WIDTH'(MIN_WAIT);
    localparam logic [CNT_WIDTH-1:0] EXP_CNT = CNT_WIDTH'(TIMEOUT - 1);

    logic [CNT_WIDTH-1:0] count;

    // Count ACCESS cycles, saturating at the top; cleared whenever not accessing.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + 1'b1;
        end
    end

    // Threshold comparisons against the current count.
    always_comb begin
        min_met = (count >= MIN_CNT);
        expired = (count == EXP_CNT);
    end

endmodule

// File: rtl/mem_bus_controller.sv
// Memory-bus front end: stall handshake with minimum wait states, mem_ready
// completion and a sticky bus-timeout fault.
// Optional feature macro: MEM_BUS_POSTED_WRITE_EN (posted writes do not stall the core).
module mem_bus_controller
    import mem_bus_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned MIN_WAIT   = 0,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    input  logic                  core_read,
    input  logic                  core_write,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  core_rdata_oe,
    output logic                  core_stall,
    output logic                  fault,
    input  logic                  fault_clear,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_re,
    output logic                  mem_we,
    input  logic                  mem_ready
);

    bus_state_t state;
    logic       op_write;
    logic       min_met;
    logic       expired;
    logic       timer_clear;
`ifdef MEM_BUS_POSTED_WRITE_EN
    logic       posted;
`endif

    assign timer_clear = reset || (state != ACCESS);

    bus_wait_timer #(
        .MIN_WAIT (MIN_WAIT),
        .TIMEOUT  (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .clear   (timer_clear),
        .min_met (min_met),
        .expired (expired)
    );

    // Access sequencer with registered strobes, read data and sticky fault.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            op_write      <= 1'b0;
            mem_re        <= 1'b0;
            mem_we        <= 1'b0;
            core_rdata_oe <= 1'b0;
            fault         <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            core_rdata    <= '0;
`ifdef MEM_BUS_POSTED_WRITE_EN
            posted        <= 1'b0;
`endif
        end else begin
            core_rdata_oe <= 1'b0;
            // Clear first so a fault raised on this same edge overrides it.
            if (fault_clear) begin
                fault <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (core_read && core_write) begin
                        state <= FAULT;
                        fault <= 1'b1;
                    end else if (core_read || core_write) begin
                        state     <= ACCESS;
                        op_write  <= core_write;
                        mem_re    <= core_read;
                        mem_we    <= core_write;
                        mem_addr  <= core_addr;
                        mem_wdata <= core_wdata;
`ifdef MEM_BUS_POSTED_WRITE_EN
                        posted    <= core_write;
`endif
                    end
                end
                ACCESS: begin
                    if (mem_ready && min_met) begin
                        state  <= DONE;
                        mem_re <= 1'b0;
                        mem_we <= 1'b0;
                        if (!op_write) begin
                            core_rdata    <= mem_rdata;
                            core_rdata_oe <= 1'b1;
                        end
                    end else if (expired) begin
                        state  <= FAULT;
                        mem_re <= 1'b0;
                        mem_we <= 1'b0;
                        fault  <= 1'b1;
                        if (!op_write) begin
                            core_rdata    <= FAULT_DATA[DATA_WIDTH-1:0];
                            core_rdata_oe <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
`ifdef MEM_BUS_POSTED_WRITE_EN
                    posted <= 1'b0;
`endif
                end
            endcase
        end
    end

    // Combinational stall back to the core.
    always_comb begin
        core_stall = 1'b0;
        if (!reset) begin
`ifdef MEM_BUS_POSTED_WRITE_EN
            // While a posted write is in flight only an actual new request stalls.
            case (state)
                IDLE:    core_stall = core_read;
                ACCESS:  core_stall = posted ? (core_read || core_write) : 1'b1;
                default: core_stall = posted && (core_read || core_write);
            endcase
`else
            case (state)
                IDLE:    core_stall = core_read || core_write;
                ACCESS:  core_stall = 1'b1;
                default: core_stall = 1'b0;
            endcase
`endif
        end
    end

endmodule

// File: tb/tb_mem_bus_controller.sv
// Cycle-table bench for mem_bus_controller (MIN_WAIT=2, TIMEOUT=8).
module tb_mem_bus_controller;

    typedef struct {
        int          idx;
        logic        rst, rd, wr;
        logic [15:0] addr, wdata, mrd;
        logic        rdy, fclr;
        logic        stall, re, we, oe;
        logic [15:0] rdata;
        logic        fault;
        logic [15:0] maddr, mwdata;
    } vec_t;

`ifdef MEM_BUS_POSTED_WRITE_EN
    localparam int unsigned WS = 0;
`else
    localparam int unsigned WS = 1;
`endif

    logic        clk;
    logic        reset;
    logic [15:0] core_addr, core_wdata, core_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        core_read, core_write, core_rdata_oe, core_stall, fault, fault_clear;
    logic        mem_re, mem_we, mem_ready;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mem_bus_controller #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (16),
        .MIN_WAIT   (2),
        .TIMEOUT    (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .core_addr     (core_addr),
        .core_wdata    (core_wdata),
        .core_read     (core_read),
        .core_write    (core_write),
        .core_rdata    (core_rdata),
        .core_rdata_oe (core_rdata_oe),
        .core_stall    (core_stall),
        .fault         (fault),
        .fault_clear   (fault_clear),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_re        (mem_re),
        .mem_we        (mem_we),
        .mem_ready     (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input int unsigned rst, rd, wr, addr, wdata, mrd, rdy, fclr,
                       input int unsigned stall, re, we, oe, rdata, flt, maddr, mwdata);
        vec_t v;
        v.idx = vecs.size();
        v.rst = rst[0];   v.rd = rd[0];   v.wr = wr[0];
        v.addr = addr[15:0]; v.wdata = wdata[15:0]; v.mrd = mrd[15:0];
        v.rdy = rdy[0];   v.fclr = fclr[0];
        v.stall = stall[0]; v.re = re[0]; v.we = we[0]; v.oe = oe[0];
        v.rdata = rdata[15:0]; v.fault = flt[0];
        v.maddr = maddr[15:0]; v.mwdata = mwdata[15:0];
        vecs.push_back(v);
    endtask

    task automatic chk1(input string name, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic chk16(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Scoreboard: compare each expected record mid-cycle.
    always @(negedge clk) begin
        vec_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk1 ("core_stall",    e.idx, core_stall,    e.stall);
            chk1 ("mem_re",        e.idx, mem_re,        e.re);
            chk1 ("mem_we",        e.idx, mem_we,        e.we);
            chk1 ("core_rdata_oe", e.idx, core_rdata_oe, e.oe);
            chk16("core_rdata",    e.idx, core_rdata,    e.rdata);
            chk1 ("fault",         e.idx, fault,         e.fault);
            chk16("mem_addr",      e.idx, mem_addr,      e.maddr);
            chk16("mem_wdata",     e.idx, mem_wdata,     e.mwdata);
        end
    end

    initial begin
        reset = 1'b1; core_read = 1'b0; core_write = 1'b0; core_addr = '0;
        core_wdata = '0; mem_rdata = '0; mem_ready = 1'b0; fault_clear = 1'b0;

        // reset state
        add(1,0,0,0,0,0,0,0,       0,0,0,0,0,0,0,0);
        add(1,0,0,0,0,0,0,0,       0,0,0,0,0,0,0,0);
        // read 0x0040, ready high: ACCESS 3 cycles, DONE with data
        add(0,1,0,'h40,0,'hBEEF,1,0, 1,0,0,0,0,0,0,0);
        for (int i = 0; i < 3; i++) add(0,1,0,'h40,0,'hBEEF,1,0, 1,1,0,0,0,0,'h40,0);
        add(0,1,0,'h40,0,'hBEEF,1,0, 0,0,0,1,'hBEEF,0,'h40,0);
        add(0,0,0,0,0,0,0,0,       0,0,0,0,'hBEEF,0,'h40,0);
        // write 0x1234 to 0x00FF, ready high
        add(0,0,1,'hFF,'h1234,0,1,0, WS,0,0,0,'hBEEF,0,'h40,0);
        for (int i = 0; i < 3; i++) add(0,0,1,'hFF,'h1234,0,1,0, 1,0,1,0,'hBEEF,0,'hFF,'h1234);
        add(0,0,0,0,0,0,1,0,       0,0,0,0,'hBEEF,0,'hFF,'h1234);
        add(0,0,0,0,0,0,0,0,       0,0,0,0,'hBEEF,0,'hFF,'h1234);
        // ready arrives on the last cycle before timeout: completion wins
        add(0,1,0,'h10,0,'h5A5A,0,0, 1,0,0,0,'hBEEF,0,'hFF,'h1234);
        for (int i = 0; i < 7; i++) add(0,1,0,'h10,0,'h5A5A,0,0, 1,1,0,0,'hBEEF,0,'h10,0);
        add(0,1,0,'h10,0,'h5A5A,1,0, 1,1,0,0,'hBEEF,0,'h10,0);
        add(0,1,0,'h10,0,'h5A5A,0,0, 0,0,0,1,'h5A5A,0,'h10,0);
        add(0,0,0,0,0,0,0,0,       0,0,0,0,'h5A5A,0,'h10,0);
        // read timeout: 8 ACCESS cycles, FAULT with all-ones data, sticky fault
        add(0,1,0,'h22,0,'h9999,0,0, 1,0,0,0,'h5A5A,0,'h10,0);
        for (int i = 0; i < 8; i++) add(0,1,0,'h22,0,'h9999,0,0, 1,1,0,0,'h5A5A,0,'h22,0);
        add(0,1,0,'h22,0,'h9999,0,0, 0,0,0,1,'hFFFF,1,'h22,0);
        add(0,0,0,0,0,0,0,0,       0,0,0,0,'hFFFF,1,'h22,0);
        add(0,0,0,0,0,0,1,1,       0,0,0,0,'hFFFF,1,'h22,0);
        add(0,0,0,0,0,0,0,0,       0,0,0,0,'hFFFF,0,'h22,0);
        // read and write together: no strobes, fault set despite a clear that cycle
        add(0,1,1,'h33,'h777,0,1,1, 1,0,0,0,'hFFFF,0,'h22,0);
        add(0,1,1,'h33,'h777,0,1,0, 0,0,0,0,'hFFFF,1,'h22,0);
        add(0,0,0,0,0,0,0,0,       0,0,0,0,'hFFFF,1,'h22,0);
        add(0,0,0,0,0,0,0,1,       0,0,0,0,'hFFFF,1,'h22,0);
        add(0,0,0,0,0,0,0,0,       0,0,0,0,'hFFFF,0,'h22,0);
        // reset in the second ACCESS cycle, then a clean read
        add(0,1,0,'h44,0,'h3333,0,0, 1,0,0,0,'hFFFF,0,'h22,0);
        add(0,1,0,'h44,0,'h3333,0,0, 1,1,0,0,'hFFFF,0,'h44,0);
        add(1,1,0,'h44,0,'h3333,0,0, 0,1,0,0,'hFFFF,0,'h44,0);
        add(0,0,0,0,0,0,0,0,       0,0,0,0,0,0,0,0);
        add(0,1,0,'h50,0,'h1111,1,0, 1,0,0,0,0,0,0,0);
        for (int i = 0; i < 3; i++) add(0,1,0,'h50,0,'h1111,1,0, 1,1,0,0,0,0,'h50,0);
        add(0,1,0,'h50,0,'h1111,1,0, 0,0,0,1,'h1111,0,'h50,0);
        add(0,0,0,0,0,0,0,0,       0,0,0,0,'h1111,0,'h50,0);
`ifdef MEM_BUS_POSTED_WRITE_EN
        // posted write, then a read that waits for the write to finish
        add(0,0,1,'h60,'hABCD,0,1,0, 0,0,0,0,'h1111,0,'h50,0);
        for (int i = 0; i < 3; i++) add(0,1,0,'h70,0,'h2222,1,0, 1,0,1,0,'h1111,0,'h60,'hABCD);
        add(0,1,0,'h70,0,'h2222,1,0, 1,0,0,0,'h1111,0,'h60,'hABCD);
        add(0,1,0,'h70,0,'h2222,1,0, 1,0,0,0,'h1111,0,'h60,'hABCD);
        for (int i = 0; i < 3; i++) add(0,1,0,'h70,0,'h2222,1,0, 1,1,0,0,'h1111,0,'h70,0);
        add(0,1,0,'h70,0,'h2222,1,0, 0,0,0,1,'h2222,0,'h70,0);
        add(0,0,0,0,0,0,0,0,       0,0,0,0,'h2222,0,'h70,0);
`endif

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            reset       = vecs[i].rst;
            core_read   = vecs[i].rd;
            core_write  = vecs[i].wr;
            core_addr   = vecs[i].addr;
            core_wdata  = vecs[i].wdata;
            mem_rdata   = vecs[i].mrd;
            mem_ready   = vecs[i].rdy;
            fault_clear = vecs[i].fclr;
            sb.push_back(vecs[i]);
        end
        @(posedge clk);
        #6;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
